// File: rtl/bowling_throw_sequencer_pkg.sv
// rtl/bowling_throw_sequencer_pkg.sv - shared constants and FSM state type for the throw sequencer
//
// Purpose: game constants and the sequencer state enumeration used by the
// sequencer top and its testbench.
package bowling_throw_sequencer_pkg;

    localparam int PINS_PER_FRAME = 10;
    localparam int LAST_FRAME     = 10;
    localparam int MAX_THROW      = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bowling_throw_sequencer_if.sv
// rtl/bowling_throw_sequencer_if.sv - update link between throw sequencer and score keeper
//
// Purpose: carries the (N, UPD) update stream towards the score keeper and the
// game-finished flag back from it.
//   N       : pin count of the current throw (sequencer -> keeper)
//   UPD     : one-cycle update strobe (sequencer -> keeper)
//   done_in : game finished (keeper -> sequencer)
interface bowling_throw_sequencer_if;

    logic [3:0] N;
    logic       UPD;
    logic       done_in;

    modport master (
        output N,
        output UPD,
        input  done_in
    );

    modport slave (
        input  N,
        input  UPD,
        output done_in
    );

endinterface

// File: rtl/bowling_throw_sequencer_button_debouncer.sv
// rtl/bowling_throw_sequencer_button_debouncer.sv - throw button synchroniser, debouncer and press detector
//
// Purpose: conditions the raw asynchronous throw button.
//   clock     : system clock
//   reset     : synchronous active-high reset
//   btn_raw   : raw bouncy button
//   press_evt : one-cycle pulse on the accepted 0->1 transition
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          level;

    // cnt counts consecutive synchronised samples that disagree with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_ff   <= 2'b00;
            cnt       <= '0;
            level     <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[0], btn_raw};
            press_evt <= 1'b0;
            if (sync_ff[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level     <= sync_ff[1];
                cnt       <= '0;
                press_evt <= sync_ff[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bowling_throw_sequencer.sv
// rtl/bowling_throw_sequencer.sv - validates throws and emits the (N, UPD) stream for the score keeper
//
// Purpose: turns debounced throw presses into validated pin-count updates,
// tracking frame, throw and pins standing including tenth-frame bonus throws.
//   clock, reset  : clock and synchronous active-high reset
//   sw_pins       : pins knocked down for the next throw
//   throw_btn     : raw throw button
//   score         : N/UPD out, done_in in (score keeper link)
//   reject        : one-cycle pulse on an invalid throw
//   frame         : current frame 1..10
//   throw_num     : throw within frame 1..3
//   pins_standing : pins standing before the next throw
//   busy          : high from CHECK through HOLD
//   game_over     : sticky, high in DONE
module bowling_throw_sequencer
    import bowling_throw_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      sw_pins,
    input  logic                            throw_btn,
    bowling_throw_sequencer_if.master       score,
    output logic                            reject,
    output logic [3:0]                      frame,
    output logic [1:0]                      throw_num,
    output logic [3:0]                      pins_standing,
    output logic                            busy,
    output logic                            game_over
);

    localparam logic [3:0] PINS4   = 4'(PINS_PER_FRAME);
    localparam logic [3:0] LAST4   = 4'(LAST_FRAME);
    localparam logic [1:0] THROW3  = 2'(MAX_THROW);
    localparam int         HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state;
    logic          press_evt;
    logic [3:0]    n_reg;
    logic [3:0]    n_q;
    logic          upd_q;
    logic [HW-1:0] hold_cnt;
    logic          strike10;
    logic          done_pend;

    logic [3:0]    nxt_frame;
    logic [1:0]    nxt_throw;
    logic [3:0]    nxt_pins;
    logic          nxt_strike10;
    logic          nxt_over;

    assign score.N   = n_q;
    assign score.UPD = upd_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (throw_btn),
        .press_evt (press_evt)
    );

    // Bookkeeping outcome of the throw held in n_reg. n_reg has already been
    // validated against pins_standing, so the subtractions cannot underflow.
    // When the game ends, frame/throw/pins are left as they were.
    always_comb begin
        nxt_frame    = frame;
        nxt_throw    = throw_num;
        nxt_pins     = pins_standing;
        nxt_strike10 = strike10;
        nxt_over     = 1'b0;
        if (frame != LAST4) begin
            if (throw_num == 2'd1 && n_reg == PINS4) begin
                nxt_frame = frame + 4'd1;
                nxt_pins  = PINS4;
            end else if (throw_num == 2'd1) begin
                nxt_pins  = pins_standing - n_reg;
                nxt_throw = 2'd2;
            end else begin
                nxt_frame = frame + 4'd1;
                nxt_throw = 2'd1;
                nxt_pins  = PINS4;
            end
        end else begin
            case (throw_num)
                2'd1: begin
                    nxt_throw = 2'd2;
                    if (n_reg == PINS4) begin
                        nxt_pins     = PINS4;
                        nxt_strike10 = 1'b1;
                    end else begin
                        nxt_pins = pins_standing - n_reg;
                    end
                end
                2'd2: begin
                    if (strike10) begin
                        // Fresh rack after the strike; a second strike racks again.
                        nxt_pins  = (n_reg == PINS4) ? PINS4 : PINS4 - n_reg;
                        nxt_throw = THROW3;
                    end else if (pins_standing == n_reg) begin
                        nxt_pins  = PINS4;
                        nxt_throw = THROW3;
                    end else begin
                        nxt_over = 1'b1;
                    end
                end
                default: nxt_over = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            n_reg         <= 4'd0;
            n_q           <= 4'd0;
            upd_q         <= 1'b0;
            reject        <= 1'b0;
            frame         <= 4'd1;
            throw_num     <= 2'd1;
            pins_standing <= PINS4;
            busy          <= 1'b0;
            game_over     <= 1'b0;
            hold_cnt      <= '0;
            strike10      <= 1'b0;
            done_pend     <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            reject <= 1'b0;
            // A done flag seen while busy is remembered for the next IDLE cycle.
            if (score.done_in) begin
                done_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (score.done_in || done_pend) begin
                        state     <= DONE;
                        game_over <= 1'b1;
                    end else if (press_evt) begin
                        n_reg <= sw_pins;
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (n_reg > pins_standing) begin
                        reject <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        upd_q <= 1'b1;
                        n_q   <= n_reg;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        frame         <= nxt_frame;
                        throw_num     <= nxt_throw;
                        pins_standing <= nxt_pins;
                        strike10      <= nxt_strike10;
                        busy          <= 1'b0;
                        if (nxt_over) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bowling_throw_sequencer.sv
// tb/tb_bowling_throw_sequencer.sv - self-checking bench for the throw sequencer
module tb_bowling_throw_sequencer;

    localparam int DEB  = 16;
    localparam int HOLD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw_pins = 4'd0;
    logic       throw_btn = 1'b0;
    logic       reject;
    logic [3:0] frame;
    logic [1:0] throw_num;
    logic [3:0] pins_standing;
    logic       busy;
    logic       game_over;

    bowling_throw_sequencer_if sif ();

    bowling_throw_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sw_pins       (sw_pins),
        .throw_btn     (throw_btn),
        .score         (sif.master),
        .reject        (reject),
        .frame         (frame),
        .throw_num     (throw_num),
        .pins_standing (pins_standing),
        .busy          (busy),
        .game_over     (game_over)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int rolls[$];
    bit ext_done = 1'b0;

    always @(posedge clock) begin
        if (reset) upd_cnt <= 0;
        else if (sif.UPD) upd_cnt <= upd_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Game state derived from the whole list of accepted rolls: frames 1..9
    // are parsed as whole frames, the tenth frame by its roll count.
    function automatic void model(output int f, output int t, output int p, output bit over);
        int n = rolls.size();
        int i = 0;
        f = 1; t = 1; p = 10; over = 1'b0;
        while (f < 10 && i < n) begin
            if (rolls[i] == 10) begin i++; f++; end
            else if (i + 1 < n) begin i += 2; f++; end
            else break;
        end
        if (f < 10) begin
            if (i < n) begin t = 2; p = 10 - rolls[i]; end
        end else begin
            int k = n - i;
            if (k >= 1) begin
                t = 2;
                p = (rolls[i] == 10) ? 10 : 10 - rolls[i];
            end
            if (k >= 2) begin
                if (rolls[i] == 10 || rolls[i] + rolls[i+1] == 10) begin
                    t = 3;
                    p = (rolls[i] == 10 && rolls[i+1] != 10) ? 10 - rolls[i+1] : 10;
                end else begin
                    over = 1'b1;
                end
            end
            if (k >= 3) over = 1'b1;
        end
        if (ext_done) over = 1'b1;
    endfunction

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_N"}, sif.N, 0);
        chk({pfx, "_UPD"}, sif.UPD, 0);
        chk({pfx, "_reject"}, reject, 0);
        chk({pfx, "_frame"}, frame, 1);
        chk({pfx, "_throw"}, throw_num, 1);
        chk({pfx, "_pins"}, pins_standing, 10);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_game_over"}, game_over, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        throw_btn = 1'b0;
        sif.done_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rolls.delete();
        ext_done = 1'b0;
    endtask

    task automatic check_state();
        int f, t, p;
        bit over;
        model(f, t, p, over);
        chk("frame", frame, f);
        chk("throw_num", throw_num, t);
        chk("pins_standing", pins_standing, p);
        chk("game_over", game_over, over);
        chk("busy_idle", busy, 0);
        chk("upd_total", upd_cnt, rolls.size());
    endtask

    // kind: 0 = ignored, 1 = accepted update, 2 = rejected
    task automatic do_throw(input int sw, input bit bounce);
        int f, t, p, k, kind;
        bit over, hit;
        model(f, t, p, over);
        kind = over ? 0 : ((sw > p) ? 2 : 1);
        sw_pins = 4'(sw);
        if (bounce) begin
            for (int b = 0; b < 10; b++) begin
                throw_btn = ~throw_btn;
                repeat ($urandom_range(1, 6)) @(negedge clock);
            end
        end
        throw_btn = 1'b1;
        hit = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (sif.UPD || reject) begin
                hit = 1'b1;
                break;
            end
        end
        case (kind)
            1: begin
                chk("upd_seen", sif.UPD, 1);
                if (!bounce) chk("latency", k, DEB + 4);
                chk("n_value", sif.N, sw);
                chk("busy_pulse", busy, 1);
                chk("reject_quiet", reject, 0);
                @(negedge clock);
                chk("upd_width", sif.UPD, 0);
                repeat (HOLD - 1) @(negedge clock);
                chk("n_hold", sif.N, sw);
                rolls.push_back(sw);
            end
            2: begin
                chk("reject_seen", reject, 1);
                chk("reject_no_upd", sif.UPD, 0);
                @(negedge clock);
                chk("reject_width", reject, 0);
            end
            default: chk("ignored", hit, 0);
        endcase
        throw_btn = 1'b0;
        repeat (DEB + 10) @(negedge clock);
        check_state();
    endtask

    initial begin
        int f, t, p, sw;
        bit over;
        sif.done_in = 1'b0;

        do_reset();
        check_reset_values("reset");

        // open frame 7/2
        do_throw(7, 0);
        do_throw(2, 0);

        // invalid second throw, then a valid one
        do_reset();
        do_throw(7, 0);
        do_throw(5, 0);
        do_throw(3, 0);

        // short glitch gives nothing; a bouncy press gives one update
        do_reset();
        throw_btn = 1'b1;
        repeat (3) @(negedge clock);
        throw_btn = 1'b0;
        repeat (40) @(negedge clock);
        chk("short_pulse_upd", upd_cnt, 0);
        chk("short_pulse_busy", busy, 0);
        do_throw(4, 1);

        // perfect game plus one extra press
        do_reset();
        for (int i = 0; i < 12; i++) do_throw(10, 0);
        do_throw(10, 0);

        // open tenth: no third throw
        do_reset();
        for (int i = 0; i < 18; i++) do_throw(0, 0);
        do_throw(3, 0);
        do_throw(4, 0);
        do_throw(2, 0);

        // spare in the tenth: bonus throw, then game over
        do_reset();
        for (int i = 0; i < 18; i++) do_throw(0, 0);
        do_throw(6, 0);
        do_throw(4, 0);
        do_throw(5, 0);
        do_throw(1, 0);

        // done_in from the score keeper while idle
        do_reset();
        sif.done_in = 1'b1;
        @(negedge clock);
        chk("done_game_over", game_over, 1);
        sif.done_in = 1'b0;
        ext_done = 1'b1;
        do_throw(3, 0);

        // reset while holding N
        do_reset();
        sw_pins = 4'd5;
        throw_btn = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (sif.UPD) break;
        end
        chk("hold_upd_seen", sif.UPD, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        throw_btn = 1'b0;
        @(negedge clock);
        check_reset_values("hold_reset");
        reset = 1'b0;
        rolls.delete();
        repeat (40) @(negedge clock);
        chk("hold_reset_no_upd", upd_cnt, 0);
        chk("hold_reset_frame", frame, 1);

        // randomized games against the roll-history model
        for (int g = 0; g < 3; g++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                model(f, t, p, over);
                if (over) break;
                if ($urandom_range(0, 4) == 0) sw = $urandom_range(p + 1, 15);
                else sw = $urandom_range(0, p);
                do_throw(sw, 0);
            end
            do_throw($urandom_range(0, 10), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bowling_throw_sequencer.md
Name: bowling_throw_sequencer

Overview:
- Front end of the bowling score keeping system. Turns the player's pin-count switches and throw button into the (N, UPD) update stream that the score keeper consumes.
- Conditions the button (synchroniser and debouncer) and validates each throw against the pins still standing. It tracks frame and throw, including tenth-frame bonus throws.
- Emits a one-cycle UPD with N held stable long enough for the score keeper to add bonus points. Stops issuing throws at game end.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles needed to accept a new button level.
- HOLD_CYCLES, 4: cycles N is held stable after the UPD cycle. Must be ≥ 3.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- sw_pins  in  4  pins knocked down for the next throw (raw switches, assumed static while the button is pressed).
- throw_btn  in  1  raw, asynchronous, bouncy throw button.
- done_in  in  1  game-finished flag from the score keeper.
- N  out  4  pin count presented to the score keeper.
- UPD  out  1  one-cycle update strobe.
- reject  out  1  one-cycle pulse when a throw is invalid.
- frame  out  4  current frame, 1..10.
- throw_num  out  2  throw within the frame, 1..3.
- pins_standing  out  4  pins standing before the next throw, 0..10.
- busy  out  1  high from CHECK through HOLD.
- game_over  out  1  sticky; high in DONE.

Behaviour:
- Reset values, applied on the first posedge with reset=1: N=0, UPD=0, reject=0, frame=1, throw_num=1, pins_standing=10, busy=0, game_over=0, state IDLE.
  - Debouncer state also clears: the accepted level is 0.
- Reset mid-operation, including during HOLD: outputs return to reset values at that edge. No further UPD is issued.
- Button conditioning:
  - 2-FF synchroniser feeds the debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current accepted level.
  - press_evt is a one-cycle pulse on the accepted 0→1 transition.
- FSM states: IDLE, CHECK, PULSE, HOLD, DONE.
  - IDLE:
    - if done_in=1, go to DONE (priority over press_evt);
    - else if press_evt, latch sw_pins into n_reg and go to CHECK.
    - press_evt in any other state is dropped.
  - CHECK: if n_reg > pins_standing (this includes any sw_pins > 10), set reject=1 for one cycle and return to IDLE. Bookkeeping is unchanged. Otherwise go to PULSE.
  - PULSE:
    - UPD=1 for exactly this one cycle; N=n_reg.
    - Latency: UPD is high in the cycle two cycles after the press_evt cycle.
  - HOLD:
    - UPD=0 and N held at n_reg for HOLD_CYCLES cycles.
    - On the last HOLD cycle, apply bookkeeping. Then go to DONE if the game is over, else IDLE.
  - DONE: absorbing until reset; game_over=1; press_evt ignored; N holds its last value.
- N is registered and changes only when entering PULSE.
- Bookkeeping, frames 1..9:
  - Throw 1 with n=10 (strike): frame+1, throw 1, pins 10.
  - Throw 1 with n<10: pins -= n, throw 2.
  - Throw 2: frame+1, throw 1, pins 10.
- Bookkeeping, frame 10:
  - Throw 1 strike: pins 10, throw 2, set strike10.
  - Throw 1 non-strike: pins -= n, throw 2.
  - Throw 2 with strike10: pins = 10 if n=10, else 10−n; throw 3.
  - Throw 2 without strike10: if pins−n=0 (spare), pins 10 and throw 3; else game over.
  - Throw 3: game over.
- Frame never exceeds 10; throw_num never exceeds 3. Subtraction never underflows because CHECK has already validated n.
- done_in asserted outside IDLE takes effect on the next IDLE cycle.

Decomposition:
- Shared package holds:
  - constants PINS_PER_FRAME=10, LAST_FRAME=10, MAX_THROW=3;
  - the FSM state enumeration (IDLE, CHECK, PULSE, HOLD, DONE), 3-bit encoded.
- One sub-module, button_debouncer: synchroniser, debounce counter and press_evt generation, parameterised by DEBOUNCE_CYCLES.
- Bookkeeping and FSM stay in the top module.

Test Plan:
- Reset, then press with sw=7, then with sw=2 → two UPD pulses, each one cycle. N=7 is held for HOLD_CYCLES+1 cycles. After throw 1: pins=3, throw_num=2. After throw 2: frame=2, throw_num=1, pins=10.
- sw=7, then sw=5 → reject=1 for one cycle with no UPD. throw_num stays 2 and pins stays 3. A following sw=3 is accepted, giving frame=2.
- throw_btn high for 3 cycles, then low, with DEBOUNCE_CYCLES=16; also bounce 10 times before holding high → no event for the short pulse. Exactly one UPD for the bounced press.
- Perfect game: 12 presses with sw=10 → 12 UPD pulses, frame 10 reached with throw_num 3. game_over=1 after the 12th HOLD. A 13th press gives no UPD and no reject.
- Nine frames of 0/0, then 3/4 → game_over=1 after the 20th UPD, with no third throw allowed. Variant with 6/4 (spare) → throw_num=3, pins=10; a 21st throw is accepted, then game_over.
- done_in=1 while in IDLE → DONE next cycle and game_over=1. Separately, reset asserted during HOLD → all outputs at reset values after that edge, and UPD stays 0.
